// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package: shared types for the HWPE stream blocks.
// Holds the packer control/flag structs and its state enum.
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_WORD_W = 32;

  typedef struct packed {
    logic        req_start;
    logic [31:0] nb_words;
  } ctrl_packer_t;

  typedef struct packed {
    logic ready_start;
    logic busy;
    logic done;
  } flags_packer_t;

  typedef enum logic [1:0] {
    PACK_IDLE,
    PACK_PACK,
    PACK_DRAIN
  } state_packer_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/hwpe_stream_packer.sv
// hwpe_stream_packer: packs 32-bit words into DATA_WIDTH beats for the
// streamer sink, counting a programmed number of words per job. A short
// final beat carries lane-accurate strobes.
// Build option: HWPE_STREAM_PACKER_ZERO_FILL_EN forces the data of lanes
// with cleared strobes to zero when a beat closes; otherwise those lanes
// keep whatever the data register last held.
module hwpe_stream_packer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NB_LANES   = DATA_WIDTH / 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  hwpe_stream_intf_stream.sink          stream_i,
  hwpe_stream_intf_stream.source        stream_o,
  input  ctrl_packer_t                  ctrl_i,
  output flags_packer_t                 flags_o
);

  localparam int unsigned LANE_W = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  state_packer_t     state_q, state_d;
  logic [31:0]       rem_q;
  logic [LANE_W-1:0] lane_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic              out_valid_q;
  logic              done_q;

  logic in_ready;
  logic accept;
  logic out_hs;
  logic last_lane;
  logic last_word;
  logic close;

  assign out_hs    = out_valid_q & stream_o.ready;
  assign accept    = stream_i.valid & in_ready;
  assign last_lane = (lane_q == LANE_W'(NB_LANES - 1));
  assign last_word = (rem_q == 32'd1);
  assign close     = accept & (last_lane | last_word);

  // Next-state and input-ready decode; clear dominates every transition.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      PACK_IDLE: begin
        if (ctrl_i.req_start && (ctrl_i.nb_words != '0)) state_d = PACK_PACK;
      end
      PACK_PACK: begin
        in_ready = ~out_valid_q | stream_o.ready;
        if (close && last_word) state_d = PACK_DRAIN;
      end
      PACK_DRAIN: begin
        if (out_hs) state_d = PACK_IDLE;
      end
      default: state_d = PACK_IDLE;
    endcase
    if (clear_i) begin
      state_d  = PACK_IDLE;
      in_ready = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= PACK_IDLE;
    else         state_q <= state_d;
  end

  // Lane merge of the accepted word; the first lane of a beat wipes old strobes.
  always_comb begin
    data_d = data_q;
    strb_d = strb_q;
    if (accept) begin
      if (lane_q == '0) strb_d = '0;
      for (int l = 0; l < int'(NB_LANES); l++) begin
        if (lane_q == LANE_W'(l)) begin
          data_d[32*l +: 32] = stream_i.data;
          strb_d[4*l +: 4]   = stream_i.strb;
        end
      end
`ifdef HWPE_STREAM_PACKER_ZERO_FILL_EN
      if (close) begin
        for (int l = 0; l < int'(NB_LANES); l++) begin
          if (strb_d[4*l +: 4] == 4'b0000) data_d[32*l +: 32] = '0;
        end
      end
`endif
    end
  end

  // Counters, output beat register and done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q       <= '0;
      lane_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_i) begin
      rem_q       <= '0;
      lane_q      <= '0;
      strb_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q == PACK_IDLE) && ctrl_i.req_start) begin
        if (ctrl_i.nb_words == '0) begin
          done_q <= 1'b1;
        end else begin
          rem_q  <= ctrl_i.nb_words;
          lane_q <= '0;
        end
      end
      if (out_hs) begin
        out_valid_q <= 1'b0;
        if (state_q == PACK_DRAIN) done_q <= 1'b1;
      end
      // An accept in the same cycle as the handshake refills the register.
      if (accept) begin
        data_q <= data_d;
        strb_q <= strb_d;
        rem_q  <= rem_q - 32'd1;
        if (close) begin
          lane_q      <= '0;
          out_valid_q <= 1'b1;
        end else begin
          lane_q <= lane_q + LANE_W'(1);
        end
      end
    end
  end

  assign stream_i.ready = in_ready;
  assign stream_o.valid = out_valid_q;
  assign stream_o.data  = data_q;
  assign stream_o.strb  = strb_q;

  assign flags_o.ready_start = (state_q == PACK_IDLE);
  assign flags_o.busy        = (state_q != PACK_IDLE);
  assign flags_o.done        = done_q;

endmodule

// File: doc/hwpe_stream_packer.md
# hwpe_stream_packer

Packs a stream of 32-bit words into full-width beats for the streamer sink, which writes `NB_LANES` TCDM words per beat. It sits directly upstream of the sink, between the engine datapath and the sink's `stream` port. It counts a programmed number of words. It emits a partially filled final beat with lane-accurate strobes, so the sink's last TCDM write masks unused bytes.

## Interface
Parameters:
- `DATA_WIDTH`, 128: output beat width. It must be a multiple of 32 and at least 32.
- `NB_LANES`, `DATA_WIDTH/32`: number of 32-bit lanes per output beat.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `clear_i`, input, 1: synchronous soft clear.
- `stream_i`, `hwpe_stream_intf_stream.sink`, 32: narrow input stream (data, strb, valid, ready).
- `stream_o`, `hwpe_stream_intf_stream.source`, `DATA_WIDTH`: packed output stream to the sink.
- `ctrl_i`, input, `ctrl_packer_t`: `req_start` (1) and `nb_words` (32, number of input words in the job).
- `flags_o`, output, `flags_packer_t`: `ready_start` (1), `busy` (1), `done` (1).

## Operation
State machine:
- **IDLE**:
  - `ready_start`=1 and `busy`=0.
  - On `req_start` with `nb_words`>0: latch `nb_words` into `rem_q`, set `lane_q`=0, go to PACK.
  - On `req_start` with `nb_words`=0: stay in IDLE and pulse `done`.
- **PACK**:
  - `stream_i.ready` = `~out_valid_q | stream_o.ready`.
  - An accepted word writes lane `lane_q` of `data_q` (bits `32*lane_q +: 32`) and strobe bits `4*lane_q +: 4` from `stream_i.strb`. Then `lane_q++` and `rem_q--`.
  - The beat closes (`out_valid_q`←1, `lane_q`←0) when the accepted word is in lane `NB_LANES-1` or `rem_q`=1.
  - If a close happens with `rem_q`=1, go to DRAIN.
- **DRAIN**:
  - `stream_i.ready`=0.
  - On the `stream_o` handshake: `out_valid_q`←0, pulse `done`, go to IDLE.
- **Boundary rules**:
  - Simultaneous output handshake and input accept in PACK: the old beat leaves, and the new word starts a fresh beat in lane 0 with all other strobes cleared. No bubble.
  - `stream_o.valid` = `out_valid_q`. Data and strb stay stable while valid && !ready.
  - `req_start` is ignored outside IDLE. Input words offered in IDLE are not accepted (`stream_i.ready`=0).
  - `rem_q` is 32-bit unsigned and never wraps: it is only decremented in PACK, where it is ≥1.
  - `clear_i` (any state): IDLE, `out_valid_q`=0, `lane_q`=0, `rem_q`=0, strobes 0, no `done`. `clear_i` has priority over every handshake in that cycle.
  - `rst_ni` low mid-job: same as clear, asynchronously. The partial beat is lost.

## Timing
- Reset values:
  - `stream_o.valid`=0, `stream_o.data`=0, `stream_o.strb`=0, `stream_i.ready`=0.
  - `ready_start`=1, `busy`=0, `done`=0.
- Latency: a beat becomes valid on the cycle after its closing word is accepted.
- Throughput: 1 word per cycle into the block and 1 beat per `NB_LANES` cycles out, sustained.
- `done` is registered. It is high for exactly 1 cycle, on the cycle after the final beat handshake (or after `req_start` with `nb_words`=0).
- `busy` = state ≠ IDLE. It is combinational from the state register.
- `NB_LANES`=1: every word closes a beat. The block behaves as a one-entry registered slice with a word counter.

## Configuration
- `HWPE_STREAM_PACKER_ZERO_FILL_EN`
  - Defined: at each beat close, lanes with cleared strobes are forced to 0 in `stream_o.data`.
  - Undefined: those lanes carry whatever the data register last held (stale). Strobes are identical in both builds.

## Structure
- Add `ctrl_packer_t`, `flags_packer_t` and the state enum `state_packer_t` (PACK_IDLE, PACK_PACK, PACK_DRAIN) to `hwpe_stream_package`.
- No sub-module is needed. The lane counter, word counter and output register live in the single module.

## Test plan
- **Full beats:** `DATA_WIDTH`=128, `nb_words`=8, input always valid (words 0x0..0x7), output always ready. Expect 2 beats: 0x00000003_00000002_00000001_00000000 then 0x7_6_5_4 lanes, strb 0xFFFF each. `done` rises 1 cycle after the second handshake.
- **Partial final beat:** `nb_words`=5. Expect beat 2 to have strb 0x000F with lane0=0x4.
  - With the macro: lanes 1–3 are 0.
  - Without the macro: beat 2 lanes 1–3 = 0x1,0x2,0x3 (stale from beat 1).
- **Backpressure:** `stream_o.ready`=0 for 10 cycles after beat 1 closes. Expect data and strb stable, `stream_i.ready`=0 throughout, and no word lost after ready returns.
- **Zero length:** `nb_words`=0. Expect no `stream_o.valid`, `done` high for exactly 1 cycle, `ready_start` staying 1.
- **Clear mid-beat:** `clear_i` after 2 accepted words. Expect IDLE next cycle with valid=0. A following job of 4 words produces one beat with those words in lanes 0–3.
- **Reset mid-job:** `rst_ni` low during DRAIN. Expect all outputs at reset values immediately, with no `done`.
